// File: rtl/wash_pkg.sv
// wash_pkg: shared encodings for the washer front panel and its consumers.
//   - run_state codes driven to time_control
//   - wash mode codes and panel defaults
//   - panel sequencer state enum and its run_state mapping
package wash_pkg;

  localparam logic [1:0] RS_IDLE  = 2'b00;
  localparam logic [1:0] RS_RUN   = 2'b01;
  localparam logic [1:0] RS_PAUSE = 2'b10;

  localparam logic [2:0] MODE_WRS   = 3'd0;  // wash, rinse, spin
  localparam logic [2:0] MODE_WR    = 3'd1;  // wash, rinse
  localparam logic [2:0] MODE_WASH  = 3'd2;  // wash only
  localparam logic [2:0] MODE_RS    = 3'd3;  // rinse, spin
  localparam logic [2:0] MODE_RINSE = 3'd4;  // rinse only
  localparam logic [2:0] MODE_SPIN  = 3'd5;  // spin only

  localparam logic [2:0] DEF_MODE  = MODE_WRS;
  localparam logic [2:0] MODE_MAX  = MODE_SPIN;
  localparam logic [2:0] DEF_WATER = 3'd2;
  localparam logic [2:0] WATER_MIN = 3'd1;
  localparam logic [2:0] WATER_MAX = 3'd5;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_DELAY,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } panel_state_e;

  // DELAY and DONE both report "run" so time_control sees no glitch through
  // the delay-to-run hand-off or the buzzer phase.
  function automatic logic [1:0] run_code(input panel_state_e s);
    case (s)
      ST_DELAY, ST_RUN, ST_DONE: run_code = RS_RUN;
      ST_PAUSE:                  run_code = RS_PAUSE;
      default:                   run_code = RS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick.sv
// sec_tick: one-second strobe generator.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count from zero (state entry)
//   en       : count while high, hold at zero while low
//   tick     : one-cycle strobe every TICK_N enabled cycles
module sec_tick #(
  parameter int TICK_N = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_N > 1) ? $clog2(TICK_N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_N - 1);

  logic [CNT_W-1:0] cnt;

  // Kept independent of clr so the strobe never loops back through the
  // sequencer's next-state logic that produces clr.
  assign tick = en && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !en || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/panel_control.sv
// panel_control: washer front-panel sequencer.
// Turns debounced key pulses into configuration and run-state for
// time_control, runs the delayed-start countdown, the finish buzzer and the
// automatic power-off after a completed cycle.
//   clk, rst                      : clock, asynchronous active-high reset
//   power_key .. delay_key        : one-cycle key pulses
//   finish                        : program complete (from time_control)
//   power_light                   : power indicator / datapath enable
//   run_state                     : 00 idle, 01 run, 10 pause
//   current_model, current_water  : selected mode 0..5, water level 1..5
//   rest_time                     : remaining delayed-start seconds
//   buzzer                        : finish alarm
module panel_control
  import wash_pkg::*;
#(
  parameter int TICK_N     = 100_000_000,
  parameter int DELAY_STEP = 10,
  parameter int DELAY_MAX  = 99,
  parameter int BUZZ_SEC   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_key,
  input  logic       start_key,
  input  logic       model_key,
  input  logic       water_key,
  input  logic       delay_key,
  input  logic       finish,
  output logic       power_light,
  output logic [1:0] run_state,
  output logic [2:0] current_model,
  output logic [2:0] current_water,
  output logic [6:0] rest_time,
  output logic       buzzer
);

  localparam logic [7:0] REST_CAP  = (DELAY_MAX > 127) ? 8'd127 : 8'(DELAY_MAX);
  localparam logic [7:0] REST_STEP = 8'(DELAY_STEP);
  localparam int         BUZZ_W    = (BUZZ_SEC > 1) ? $clog2(BUZZ_SEC) : 1;
  localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_SEC - 1);

  panel_state_e      state, state_n;
  logic [2:0]        model_n, water_n;
  logic [6:0]        rest_n;
  logic [BUZZ_W-1:0] buzz_cnt, buzz_n;
  logic              tick, tick_clr, tick_en;

  // Sum is formed one bit wider so an oversized step cannot wrap before
  // being clamped.
  function automatic logic [6:0] sat_rest(input logic [7:0] sum);
    sat_rest = (sum > REST_CAP) ? REST_CAP[6:0] : sum[6:0];
  endfunction

  sec_tick #(
    .TICK_N (TICK_N)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  assign tick_en  = (state == ST_DELAY) || (state == ST_DONE);
  assign tick_clr = ((state_n == ST_DELAY) && (state != ST_DELAY)) ||
                    ((state_n == ST_DONE)  && (state != ST_DONE));

  // Next-state: power pre-empts everything; within a state, start beats the
  // configuration keys, and keys beat the second tick and finish.
  always_comb begin
    state_n = state;
    model_n = current_model;
    water_n = current_water;
    rest_n  = rest_time;
    buzz_n  = buzz_cnt;

    if (power_key) begin
      if (state == ST_OFF) begin
        state_n = ST_IDLE;
        model_n = DEF_MODE;
        water_n = DEF_WATER;
        rest_n  = '0;
      end else begin
        state_n = ST_OFF;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_key) begin
            state_n = (rest_time != '0) ? ST_DELAY : ST_RUN;
          end else if (model_key) begin
            model_n = (current_model >= MODE_MAX) ? MODE_WRS : current_model + 3'd1;
          end else if (water_key) begin
            water_n = (current_water >= WATER_MAX) ? WATER_MIN : current_water + 3'd1;
          end else if (delay_key) begin
            rest_n = sat_rest({1'b0, rest_time} + REST_STEP);
          end
        end
        ST_DELAY: begin
          if (start_key) begin
            state_n = ST_IDLE;
            rest_n  = '0;
          end else if (tick) begin
            if (rest_time <= 7'd1) begin
              rest_n  = '0;
              state_n = ST_RUN;
            end else begin
              rest_n = rest_time - 7'd1;
            end
          end
        end
        ST_RUN: begin
          if (start_key) begin
            state_n = ST_PAUSE;
          end else if (finish) begin
            state_n = ST_DONE;
            buzz_n  = '0;
          end
        end
        ST_PAUSE: begin
          if (start_key) begin
            state_n = ST_RUN;
          end
        end
        ST_DONE: begin
          if (tick) begin
            if (buzz_cnt == BUZZ_LAST) begin
              state_n = ST_OFF;
            end else begin
              buzz_n = buzz_cnt + BUZZ_W'(1);
            end
          end
        end
        default: state_n = ST_OFF;
      endcase
    end
  end

  // Register stage: outputs are decoded from the next state so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_OFF;
      current_model <= DEF_MODE;
      current_water <= DEF_WATER;
      rest_time     <= '0;
      buzz_cnt      <= '0;
      power_light   <= 1'b0;
      run_state     <= RS_IDLE;
      buzzer        <= 1'b0;
    end else begin
      state         <= state_n;
      current_model <= model_n;
      current_water <= water_n;
      rest_time     <= rest_n;
      buzz_cnt      <= buzz_n;
      power_light   <= (state_n != ST_OFF);
      run_state     <= run_code(state_n);
      buzzer        <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_panel_control.sv
module tb_panel_control;

  localparam int TICK_N = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       power_key, start_key, model_key, water_key, delay_key, finish;
  logic       power_light, buzzer;
  logic [1:0] run_state;
  logic [2:0] current_model, current_water;
  logic [6:0] rest_time;

  panel_control #(
    .TICK_N     (TICK_N),
    .DELAY_STEP (10),
    .DELAY_MAX  (99),
    .BUZZ_SEC   (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .power_key     (power_key),
    .start_key     (start_key),
    .model_key     (model_key),
    .water_key     (water_key),
    .delay_key     (delay_key),
    .finish        (finish),
    .power_light   (power_light),
    .run_state     (run_state),
    .current_model (current_model),
    .current_water (current_water),
    .rest_time     (rest_time),
    .buzzer        (buzzer)
  );

  always #5 clk = ~clk;

  // key bits: {power, start, model, water, delay, finish}
  localparam logic [5:0] K_NONE = 6'b000000;
  localparam logic [5:0] K_PWR  = 6'b100000;
  localparam logic [5:0] K_STA  = 6'b010000;
  localparam logic [5:0] K_MOD  = 6'b001000;
  localparam logic [5:0] K_WAT  = 6'b000100;
  localparam logic [5:0] K_DLY  = 6'b000010;
  localparam logic [5:0] K_FIN  = 6'b000001;

  typedef struct {
    logic [5:0]  keys;
    logic [16:0] exp;
  } vec_t;

  typedef struct {
    logic [16:0] exp;
    int          id;
  } sb_t;

  vec_t tbl[$];
  sb_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Expected output word: {light, run_state, model, water, rest, buzzer}
  function automatic logic [16:0] ex(input logic l, input logic [1:0] rs,
                                     input int m, input int w, input int r,
                                     input logic b);
    ex = {l, rs, 3'(m), 3'(w), 7'(r), b};
  endfunction

  function automatic logic [16:0] observed();
    observed = {power_light, run_state, current_model, current_water, rest_time, buzzer};
  endfunction

  task automatic cmp(input logic [16:0] got, input logic [16:0] want, input int id);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL step %0d: {light,rs,model,water,rest,buzz} got %h required %h",
                  id, got, want);
  endtask

  task automatic step(input logic [5:0] k, input logic [16:0] e, input int id);
    @(negedge clk);
    {power_key, start_key, model_key, water_key, delay_key, finish} = k;
    exp_q.push_back('{e, id});
  endtask

  // Scoreboard: each driven cycle's expectation is checked just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      sb_t s;
      s = exp_q.pop_front();
      cmp(observed(), s.exp, s.id);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    {power_key, start_key, model_key, water_key, delay_key, finish} = K_NONE;
    repeat (2) @(negedge clk);
    cmp(observed(), ex(0, 2'b00, 0, 2, 0, 0), 0);
    rst = 1'b0;

    // Power-on, mode/water wrap, hold through OFF, key priority, pause/resume.
    tbl.push_back('{K_PWR, ex(1, 2'b00, 0, 2, 0, 0)});
    for (int i = 1; i <= 7; i++) tbl.push_back('{K_MOD, ex(1, 2'b00, i % 6, 2, 0, 0)});
    tbl.push_back('{K_WAT, ex(1, 2'b00, 1, 3, 0, 0)});
    tbl.push_back('{K_WAT, ex(1, 2'b00, 1, 4, 0, 0)});
    tbl.push_back('{K_WAT, ex(1, 2'b00, 1, 5, 0, 0)});
    tbl.push_back('{K_WAT, ex(1, 2'b00, 1, 1, 0, 0)});
    tbl.push_back('{K_PWR, ex(0, 2'b00, 1, 1, 0, 0)});
    tbl.push_back('{K_PWR, ex(1, 2'b00, 0, 2, 0, 0)});
    tbl.push_back('{K_STA | K_MOD, ex(1, 2'b01, 0, 2, 0, 0)});
    tbl.push_back('{K_MOD, ex(1, 2'b01, 0, 2, 0, 0)});
    tbl.push_back('{K_STA, ex(1, 2'b10, 0, 2, 0, 0)});
    tbl.push_back('{K_WAT | K_FIN, ex(1, 2'b10, 0, 2, 0, 0)});
    tbl.push_back('{K_STA, ex(1, 2'b01, 0, 2, 0, 0)});
    tbl.push_back('{K_FIN, ex(1, 2'b01, 0, 2, 0, 1)});
    foreach (tbl[i]) step(tbl[i].keys, tbl[i].exp, i + 1);

    // Buzzer runs three seconds, then automatic power-off.
    for (int c = 1; c <= 14; c++) step(K_NONE, ex(1, 2'b01, 0, 2, 0, 1), 100 + c);
    step(K_NONE, ex(0, 2'b00, 0, 2, 0, 0), 115);

    // Delay saturation, countdown, cancel on a tick edge.
    step(K_PWR, ex(1, 2'b00, 0, 2, 0, 0), 200);
    step(K_MOD | K_WAT, ex(1, 2'b00, 1, 2, 0, 0), 201);
    step(K_WAT | K_DLY, ex(1, 2'b00, 1, 3, 0, 0), 202);
    for (int i = 1; i <= 11; i++)
      step(K_DLY, ex(1, 2'b00, 1, 3, (10 * i > 99) ? 99 : 10 * i, 0), 202 + i);
    step(K_FIN, ex(1, 2'b00, 1, 3, 99, 0), 220);
    step(K_STA, ex(1, 2'b01, 1, 3, 99, 0), 221);
    for (int c = 1; c <= 4; c++) step(K_NONE, ex(1, 2'b01, 1, 3, 99, 0), 221 + c);
    step(K_NONE, ex(1, 2'b01, 1, 3, 98, 0), 226);
    for (int c = 1; c <= 4; c++) step(K_NONE, ex(1, 2'b01, 1, 3, 98, 0), 226 + c);
    step(K_STA, ex(1, 2'b00, 1, 3, 0, 0), 231);

    // Full 10-second countdown into RUN; config keys ignored in DELAY.
    step(K_DLY, ex(1, 2'b00, 1, 3, 10, 0), 300);
    step(K_STA, ex(1, 2'b01, 1, 3, 10, 0), 301);
    for (int c = 1; c <= 50; c++)
      step((c == 7) ? (K_DLY | K_MOD | K_WAT) : K_NONE,
           ex(1, 2'b01, 1, 3, 10 - c / TICK_N, 0), 301 + c);
    step(K_STA, ex(1, 2'b10, 1, 3, 0, 0), 360);
    step(K_FIN, ex(1, 2'b10, 1, 3, 0, 0), 361);
    step(K_STA, ex(1, 2'b01, 1, 3, 0, 0), 362);
    step(K_FIN, ex(1, 2'b01, 1, 3, 0, 1), 363);
    for (int c = 1; c <= 3; c++) step(K_NONE, ex(1, 2'b01, 1, 3, 0, 1), 363 + c);
    step(K_PWR | K_STA, ex(0, 2'b00, 1, 3, 0, 0), 367);

    // Power beats start while running.
    step(K_PWR, ex(1, 2'b00, 0, 2, 0, 0), 400);
    step(K_STA, ex(1, 2'b01, 0, 2, 0, 0), 401);
    step(K_PWR | K_STA, ex(0, 2'b00, 0, 2, 0, 0), 402);

    // Asynchronous reset in the middle of a delayed start.
    step(K_PWR, ex(1, 2'b00, 0, 2, 0, 0), 500);
    step(K_MOD, ex(1, 2'b00, 1, 2, 0, 0), 501);
    step(K_DLY, ex(1, 2'b00, 1, 2, 10, 0), 502);
    step(K_STA, ex(1, 2'b01, 1, 2, 10, 0), 503);
    step(K_NONE, ex(1, 2'b01, 1, 2, 10, 0), 504);
    step(K_NONE, ex(1, 2'b01, 1, 2, 10, 0), 505);
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp(observed(), ex(0, 2'b00, 0, 2, 0, 0), 506);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) step(K_NONE, ex(0, 2'b00, 0, 2, 0, 0), 506 + c);
    step(K_PWR, ex(1, 2'b00, 0, 2, 0, 0), 513);
    step(K_NONE, ex(1, 2'b00, 0, 2, 0, 0), 514);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/panel_control.md
# panel_control

Front-panel sequencer for the washer. It turns debounced key pulses into the configuration and run-state signals consumed by `time_control`: `power_light`, `run_state`, `current_model`, `current_water`, and `rest_time`. It also owns the delayed-start countdown, the finish buzzer, and the automatic power-off after a completed cycle. It sits between the key debouncers and `time_control`, and its outputs drive that block's inputs directly.

## Interface
- `TICK_N`, default 100_000_000: clock cycles per second; benches use 5.
- `DELAY_STEP`, default 10: seconds added to `rest_time` per `delay_key` press.
- `DELAY_MAX`, default 99: saturation limit of `rest_time`.
- `BUZZ_SEC`, default 3: buzzer duration in seconds.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `power_key`  in  1  one-cycle pulse that toggles power.
- `start_key`  in  1  one-cycle pulse for start, pause, resume, or cancel of a delayed start.
- `model_key`  in  1  one-cycle pulse that steps the wash mode.
- `water_key`  in  1  one-cycle pulse that steps the water level.
- `delay_key`  in  1  one-cycle pulse that adds delay time.
- `finish`  in  1  level from `time_control`; the program has completed.
- `power_light`  out  1  power indicator and datapath enable.
- `run_state`  out  2  00 idle, 01 run, 10 pause; 11 is never driven.
- `current_model`  out  3  mode 0..5 (0 wash-rinse-spin … 5 spin only).
- `current_water`  out  3  water level 1..5.
- `rest_time`  out  7  remaining delayed-start seconds.
- `buzzer`  out  1  finish alarm.

## Operation
- FSM states and the `run_state` each drives:
  - OFF: 00, with `power_light`=0.
  - IDLE: 00.
  - DELAY: 01.
  - RUN: 01.
  - PAUSE: 10.
  - DONE: 01.
- In every state other than OFF, `power_light`=1.
- Key priority when several keys arrive in one cycle: power > start > model > water > delay. Only the highest-priority key is acted on; the others are dropped.
- Power key:
  - In OFF, it goes to IDLE and loads the defaults: model 0, water 2, `rest_time` 0.
  - In any other state, it goes to OFF.
- Mode, water and delay keys are honoured only in IDLE and ignored elsewhere:
  - `model_key`: model+1, wrapping 5→0.
  - `water_key`: water+1, wrapping 5→1.
  - `delay_key`: `rest_time` = min(`rest_time`+`DELAY_STEP`, `DELAY_MAX`).
- Start key by state:
  - IDLE: goes to DELAY if `rest_time`>0, otherwise to RUN.
  - DELAY: cancels; `rest_time` is cleared to 0 and the state returns to IDLE.
  - RUN: goes to PAUSE.
  - PAUSE: goes to RUN.
  - DONE: ignored.
- DELAY behaviour:
  - On each second tick, `rest_time` decrements.
  - The tick that takes it 1→0 also moves the state to RUN. `run_state` stays 01 throughout, so `time_control` begins counting once `rest_time` reads 0.
- RUN behaviour: when `finish`=1, go to DONE with `buzzer`=1.
  - `finish` is ignored in every other state.
- DONE behaviour:
  - After `BUZZ_SEC` ticks, `buzzer`=0 and the state goes to OFF. The power-down clears `finish` inside `time_control`.
  - A power key during DONE goes to OFF immediately, with `buzzer`=0.
- Model and water values are held through OFF. They are reloaded to their defaults only on the OFF→IDLE transition.

## Timing
- Reset values (asynchronous, applied immediately on `rst`):
  - State OFF.
  - `power_light`=0, `run_state`=00, `buzzer`=0.
  - `current_model`=0, `current_water`=2, `rest_time`=0.
  - Tick counter = 0.
- Reset asserted mid-DELAY or mid-DONE aborts to the reset values with no further tick.
- All outputs are registered. A key sampled at edge k has its effect visible after edge k (latency 1).
- `finish` sampled high at edge k gives DONE and `buzzer`=1 after edge k.
- Second tick:
  - The tick counter clears on every entry to DELAY or DONE.
  - A tick fires when the counter equals `TICK_N`-1; the counter then returns to 0. Ticks therefore occur exactly `TICK_N` cycles after entry and every `TICK_N` cycles thereafter.
  - The counter holds at 0 in all other states.
- A cancel or power key arriving on the same edge as a tick wins; the decrement is not applied.
- `rest_time` arithmetic is done at 8 bits and then saturated, so it never wraps past 127.

## Structure
- Package `wash_pkg` holds:
  - `run_state` encodings: `RS_IDLE`, `RS_RUN`, `RS_PAUSE`.
  - Mode codes `MODE_WRS`…`MODE_SPIN`.
  - The panel state enum.
  - Defaults: `DEF_WATER`=2, `MODE_MAX`=5, `WATER_MIN`=1, `WATER_MAX`=5.
- Sub-module `sec_tick`: parameter `TICK_N`; inputs `clk`, `rst`, `clr`, `en`; output `tick`. One instance lives in `panel_control`.

## Test plan
- Reset, then `power_key` → `power_light`=1, `run_state`=00, model 0, water 2. Then `model_key`×7 → model 1; `water_key`×4 → water 1.
- IDLE with `delay_key`×11 → `rest_time` saturates at 99. Then `start_key` (`TICK_N`=5) → `run_state`=01, `rest_time` 98 after 5 cycles. `start_key` mid-countdown → IDLE, `rest_time`=0.
- `rest_time`=10, then `start_key` → after 50 cycles `rest_time`=0 and the state is RUN. `start_key` → `run_state`=10; `start_key` again → 01.
- RUN with a `finish` pulse → `buzzer`=1 on the next cycle. After 15 cycles → `buzzer`=0, `power_light`=0, `run_state`=00.
- `power_key` and `start_key` in the same cycle while in RUN → OFF. `rst` asserted during DELAY → all outputs return to reset values asynchronously.
